// File: rtl/brick_grid_collider.sv
// Per-frame brick collision engine: probes the ball's leading edges against an
// alive-bitmap, resolves bounce directions and streams one erase per cleared brick.
module brick_grid_collider #(
   parameter int BRICK_COLS = 10,
   parameter int BRICK_ROWS = 2,
   parameter int BRICK_W    = 16,
   parameter int BRICK_H    = 10,
   parameter int BALL_SIZE  = 2,
   parameter int GRID_Y0    = 0,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   localparam int N   = BRICK_COLS * BRICK_ROWS,
   localparam int A_W = $clog2(N),
   localparam int C_W = $clog2(N + 1)
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           start,
   input  logic [X_W-1:0] ball_x,
   input  logic [Y_W-1:0] ball_y,
   input  logic           dir_right,
   input  logic           dir_down,
   input  logic           load_level,
   output logic           busy,
   output logic           done,
   output logic           hit,
   output logic           new_right,
   output logic           new_down,
   output logic           erase_valid,
   output logic [A_W-1:0] erase_addr,
   output logic [C_W-1:0] bricks_left,
   output logic           level_clear
);
   localparam int PW = X_W + Y_W + 2;
   localparam int NP = 1 << A_W;

   typedef enum logic [3:0] {
      S_IDLE, S_PH, S_PV, S_PC, S_RES, S_ER_H, S_ER_V, S_ER_C, S_DN
   } state_t;

   state_t         state, state_nx;
   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   logic           cr, cd;
   logic           h_hit, v_hit, c_hit, c_only;
   logic [A_W-1:0] h_addr, v_addr, c_addr;
   logic [N-1:0]   alive;

   logic [X_W:0]   xl;
   logic [Y_W:0]   yl;
   logic           x_uf, y_uf, p_uf, p_hit;
   logic [PW-1:0]  px, py_rel;
   logic [A_W-1:0] p_addr;
   logic [NP-1:0]  alive_ext;

   // One shared probe unit; the state picks which of H/V/C it evaluates.
   // A grid row above GRID_Y0 wraps py_rel to a huge value and falls out of range.
   always_comb begin
      x_uf   = !cr && (cx == '0);
      y_uf   = !cd && (cy == '0);
      xl     = cr ? {1'b0, cx} + (X_W+1)'(BALL_SIZE) : {1'b0, cx} - (X_W+1)'(1);
      yl     = cd ? {1'b0, cy} + (Y_W+1)'(BALL_SIZE) : {1'b0, cy} - (Y_W+1)'(1);
      px     = PW'(xl);
      py_rel = PW'(yl) - PW'(GRID_Y0);
      p_uf   = x_uf || y_uf;
      if (state == S_PH) begin
         py_rel = PW'(cy) - PW'(GRID_Y0);
         p_uf   = x_uf;
      end
      if (state == S_PV) begin
         px   = PW'(cx);
         p_uf = y_uf;
      end
      p_addr    = A_W'((py_rel / PW'(BRICK_H)) * PW'(BRICK_COLS) + px / PW'(BRICK_W));
      alive_ext = NP'(alive);
      p_hit     = !p_uf && (px < PW'(BRICK_COLS * BRICK_W))
                  && (py_rel < PW'(BRICK_ROWS * BRICK_H)) && alive_ext[p_addr];
   end

   assign c_only = c_hit && !h_hit && !v_hit;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = S_PH;
         S_PH:   state_nx = S_PV;
         S_PV:   state_nx = S_PC;
         S_PC:   state_nx = S_RES;
         S_RES: begin
            if (h_hit)       state_nx = S_ER_H;
            else if (v_hit)  state_nx = S_ER_V;
            else if (c_only) state_nx = S_ER_C;
            else             state_nx = S_DN;
         end
         // H and V landing on the same brick erase it only once.
         S_ER_H: state_nx = (v_hit && (v_addr != h_addr)) ? S_ER_V : S_DN;
         S_ER_V: state_nx = S_DN;
         S_ER_C: state_nx = S_DN;
         S_DN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (load_level) state_nx = S_IDLE;
   end

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DN);
   assign erase_valid = (state == S_ER_H) || (state == S_ER_V) || (state == S_ER_C);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= S_IDLE;
         cx          <= '0;
         cy          <= '0;
         cr          <= 1'b0;
         cd          <= 1'b0;
         h_hit       <= 1'b0;
         v_hit       <= 1'b0;
         c_hit       <= 1'b0;
         h_addr      <= '0;
         v_addr      <= '0;
         c_addr      <= '0;
         alive       <= '1;
         bricks_left <= C_W'(N);
         level_clear <= 1'b0;
         hit         <= 1'b0;
         new_right   <= 1'b0;
         new_down    <= 1'b0;
         erase_addr  <= '0;
      end else begin
         state <= state_nx;
         if (load_level) begin
            alive       <= '1;
            bricks_left <= C_W'(N);
            level_clear <= 1'b0;
         end else begin
            if (state_nx == S_PH) begin
               cx <= ball_x;
               cy <= ball_y;
               cr <= dir_right;
               cd <= dir_down;
            end
            if (state == S_PH) begin h_hit <= p_hit; h_addr <= p_addr; end
            if (state == S_PV) begin v_hit <= p_hit; v_addr <= p_addr; end
            if (state == S_PC) begin c_hit <= p_hit; c_addr <= p_addr; end
            if (erase_valid) begin
               alive       <= alive & ~(N'(1) << erase_addr);
               bricks_left <= bricks_left - C_W'(1);
               level_clear <= (bricks_left == C_W'(1));
            end
            if (state_nx == S_ER_H) erase_addr <= h_addr;
            if (state_nx == S_ER_V) erase_addr <= v_addr;
            if (state_nx == S_ER_C) erase_addr <= c_addr;
            if (state_nx == S_DN) begin
               hit       <= h_hit || v_hit || c_only;
               new_right <= cr ^ (h_hit || c_only);
               new_down  <= cd ^ (v_hit || c_only);
            end
         end
      end
   end
endmodule

// File: tb/tb_brick_grid_collider.sv
// Randomized bench for brick_grid_collider against a per-operation timeline model.
module tb_brick_grid_collider;
   localparam int COLS = 10, ROWS = 2, BW = 16, BH = 10, BS = 2, GY0 = 0;
   localparam int N = COLS * ROWS;

   logic       clock = 1'b0, resetn = 1'b0, start = 1'b0, load_level = 1'b0;
   logic       dir_right = 1'b0, dir_down = 1'b0;
   logic [7:0] ball_x = '0;
   logic [6:0] ball_y = '0;
   logic       busy, done, hit, new_right, new_down, erase_valid, level_clear;
   logic [4:0] erase_addr, bricks_left;

   brick_grid_collider #(
      .BRICK_COLS(COLS), .BRICK_ROWS(ROWS), .BRICK_W(BW), .BRICK_H(BH),
      .BALL_SIZE(BS), .GRID_Y0(GY0), .X_W(8), .Y_W(7)
   ) dut (
      .clock(clock), .resetn(resetn), .start(start), .ball_x(ball_x), .ball_y(ball_y),
      .dir_right(dir_right), .dir_down(dir_down), .load_level(load_level),
      .busy(busy), .done(done), .hit(hit), .new_right(new_right), .new_down(new_down),
      .erase_valid(erase_valid), .erase_addr(erase_addr), .bricks_left(bricks_left),
      .level_clear(level_clear)
   );

   always #5 clock = ~clock;

   bit   alive[N];
   int   cnt = N;
   logic e_busy = 0, e_done = 0, e_ev = 0, e_hit = 0, e_nr = 0, e_nd = 0, e_lc = 0;
   int   e_ea = 0, e_bl = N, last_dc = 0;
   int   total = 0, bad = 0;
   bit   chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("erase_valid", erase_valid, e_ev);
         chk("erase_addr", erase_addr, e_ea);
         chk("hit", hit, e_hit);
         chk("new_right", new_right, e_nr);
         chk("new_down", new_down, e_nd);
         chk("bricks_left", bricks_left, e_bl);
         chk("level_clear", level_clear, e_lc);
      end
   end

   function automatic bit probe(input int px, input int py, output int a);
      a = 0;
      if (px < 0 || py < GY0 || px >= COLS * BW || py >= GY0 + ROWS * BH) return 1'b0;
      a = ((py - GY0) / BH) * COLS + px / BW;
      return alive[a];
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic refill();
      for (int a = 0; a < N; a++) alive[a] = 1'b1;
      cnt = N;
      e_bl = N;
      e_lc = 0;
   endtask

   task automatic do_load();
      step();
      load_level = 1;
      step();
      load_level = 0;
      refill();
   endtask

   // kind: 0 none, 1 load_level abort, 2 reset abort, asserted during cycle 'at'.
   // junk: cycle in which a spurious start is raised.
   task automatic op(input int x, input int y, input bit r, input bit d,
                     input int kind, input int at, input int junk);
      int xl, yl, ha, va, ca, n, dc, base, k, done_e;
      bit h, v, c, cc, ab;
      int ers[$];
      xl = r ? x + BS : x - 1;
      yl = d ? y + BS : y - 1;
      h  = probe(xl, y, ha);
      v  = probe(x, yl, va);
      c  = probe(xl, yl, ca);
      cc = c && !h && !v;
      if (h) ers.push_back(ha);
      if (v && !(h && va == ha)) ers.push_back(va);
      if (cc) ers.push_back(ca);
      n = ers.size();
      dc = 5 + n;
      last_dc = dc;
      base = cnt;
      step();
      ball_x = 8'(x); ball_y = 7'(y); dir_right = r; dir_down = d; start = 1;
      e_busy = 0; e_done = 0; e_ev = 0;
      ab = 0;
      k = 0;
      while (!ab && k < dc) begin
         k++;
         step();
         start = (k == junk);
         ball_x = 8'($urandom); ball_y = 7'($urandom);
         dir_right = 1'($urandom); dir_down = 1'($urandom);
         e_busy = 1;
         e_done = (k == dc);
         e_ev = (k >= 5 && k < 5 + n);
         if (e_ev) begin
            e_ea = ers[k-5];
            alive[ers[k-5]] = 1'b0;
         end
         done_e = (k - 5 < 0) ? 0 : ((k - 5 > n) ? n : k - 5);
         e_bl = base - done_e;
         e_lc = (e_bl == 0);
         if (k == dc) begin
            e_hit = (n > 0);
            e_nr = r ^ (h || cc);
            e_nd = d ^ (v || cc);
         end
         if (kind != 0 && k == at) begin
            ab = 1;
            if (kind == 1) load_level = 1;
            else resetn = 0;
         end
      end
      cnt = base - n;
      step();
      start = 0; load_level = 0; resetn = 1;
      e_busy = 0; e_done = 0; e_ev = 0;
      if (ab) begin
         refill();
         if (kind == 2) begin
            e_hit = 0; e_nr = 0; e_nd = 0; e_ea = 0;
         end
      end
   endtask

   initial begin
      int kind, at;
      for (int a = 0; a < N; a++) alive[a] = 1'b1;
      step();
      chk_en = 1;
      step();
      resetn = 1;
      step();
      chk("rst_bl_lit", bricks_left, 20);
      chk("rst_lc_lit", level_clear, 0);

      // vertical hit on addr 11
      op(30, 20, 1, 0, 0, 0, 0);
      chk("vhit_dc", last_dc, 6);
      chk("vhit_ea", e_ea, 11);
      chk("vhit_nd", e_nd, 1);
      chk("vhit_nr", e_nr, 1);
      chk("vhit_bl_lit", bricks_left, 19);
      op(30, 20, 1, 0, 0, 0, 0);

      // corner-only hit
      do_load();
      op(5, 20, 0, 0, 0, 0, 0);
      chk("corner_pre_ea", e_ea, 10);
      op(14, 20, 1, 0, 0, 0, 0);
      chk("corner_ea", e_ea, 11);
      chk("corner_nr_lit", new_right, 0);
      chk("corner_nd_lit", new_down, 1);

      // double hit
      do_load();
      op(14, 12, 1, 1, 0, 0, 0);
      chk("dbl_dc", last_dc, 7);
      chk("dbl_ea_lit", erase_addr, 10);
      chk("dbl_bl_lit", bricks_left, 18);

      // edges: left underflow, spurious start, aborts
      op(0, 5, 0, 1, 0, 0, 0);
      chk("uf_nr", e_nr, 0);
      op(100, 5, 1, 1, 0, 0, 2);
      op(40, 5, 0, 1, 1, 2, 0);
      chk("abort_bl_lit", bricks_left, 20);
      op(40, 5, 0, 1, 2, 3, 0);
      chk("rst_mid_hit_lit", hit, 0);

      // randomized
      for (int i = 0; i < 80; i++) begin
         kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         at = $urandom_range(1, 6);
         op($urandom_range(0, 175), $urandom_range(0, 26), 1'($urandom), 1'($urandom),
            kind, at, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
         if ($urandom_range(0, 15) == 0) do_load();
      end

      // clear the whole field
      do_load();
      for (int a = 0; a < N; a++)
         if (alive[a]) op((a % COLS) * BW + 4, (a / COLS) * BH + BH, 0, 0, 0, 0, 0);
      chk("clear_cnt", cnt, 0);
      chk("clear_lc_lit", level_clear, 1);
      chk("clear_bl_lit", bricks_left, 0);
      op(30, 20, 1, 0, 0, 0, 0);
      do_load();
      step();
      chk("reload_bl_lit", bricks_left, 20);
      chk("reload_lc_lit", level_clear, 0);
      step();
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/brick_grid_collider.md
# brick_grid_collider

Sequential, parametrised brick-field collision engine for the DX-Ball animation path. Once per frame it takes the ball's position and direction and probes the leading edges against a ROWS×COLS grid of bricks held in an internal alive-bitmap. It then returns bounce directions and clears the hit bricks, streaming one erase request per cleared brick to the VGA drawing FSM. It also tracks remaining bricks and flags level clear. It sits between the ball-motion FSM and the draw/erase datapath.

## Interface
- BRICK_COLS, 10, bricks per row
- BRICK_ROWS, 2, brick rows
- BRICK_W, 16, brick width in pixels
- BRICK_H, 10, brick height in pixels
- BALL_SIZE, 2, ball side in pixels (square)
- GRID_Y0, 0, top pixel row of the grid; grid x origin is 0
- X_W, 8 / Y_W, 7, coordinate widths
- Derived: N = COLS·ROWS; A_W = clog2(N); C_W = clog2(N+1)

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- ball_x  in  X_W  ball top-left x; captured on start
- ball_y  in  Y_W  ball top-left y; captured on start
- dir_right  in  1  current horizontal direction; captured on start
- dir_down  in  1  current vertical direction; captured on start
- load_level  in  1  refill bitmap and abort any operation
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse; results valid from this cycle
- hit  out  1  any brick struck in the last operation
- new_right  out  1  resolved horizontal direction
- new_down  out  1  resolved vertical direction
- erase_valid  out  1  one-cycle pulse per cleared brick
- erase_addr  out  A_W  row·COLS + col of the cleared brick
- bricks_left  out  C_W  alive count
- level_clear  out  1  high while bricks_left == 0

## Operation
- Bitmap: N bits, 1 = alive. Reset or load_level sets all bits to 1 and bricks_left to N.
- Leading edges:
  - xl = dir_right ? x+BALL_SIZE : x−1
  - yl = dir_down ? y+BALL_SIZE : y−1
  - Both use X_W+1 / Y_W+1 bits; x−1 or y−1 underflow counts as a miss.
- Probes:
  - H = (xl, y)
  - V = (x, yl)
  - C = (xl, yl)
- A probe (px, py) hits when px < COLS·W, GRID_Y0 ≤ py < GRID_Y0+ROWS·H, and bitmap[addr] = 1.
  - col = px / W, row = (py − GRID_Y0) / H, addr = row·COLS + col.
- FSM:
  - IDLE → PH (on start) → PV → PC → RES
  - RES → ER_H (if H hit) → ER_V (if V hit with a distinct addr) → DONE → IDLE
  - RES → ER_C (if C is the only hit) → DONE
- Resolution:
  - H hit flips new_right; V hit flips new_down.
  - C counts only if H and V both miss; a C hit flips both.
  - With no hit, new_* = dir_*.
- Each ER_* state clears its bitmap bit, decrements bricks_left, and pulses erase_valid with erase_addr.
- If H and V resolve to the same addr, that brick is cleared once and bricks_left decrements once.
- start while busy is ignored.
- load_level in any state refills the bitmap and forces IDLE; no done is issued, and hit/new_* keep their prior values.
- load_level and start in the same cycle: load_level wins and start is dropped.
- hit/new_*/erase_addr hold until the next done.

## Timing
- Reset values:
  - busy, done, hit, erase_valid = 0
  - new_right, new_down = 0
  - erase_addr = 0
  - bricks_left = N, level_clear = 0
- start sampled high in cycle 0 gives PH in cycle 1, PV in 2, PC in 3, RES in 4.
- done fires in cycle 5 with no erase, 6 with one erase, 7 with two erases.
- busy is high in cycles 1 through the done cycle.
- erase_valid fires in cycles 5 and 6 as applicable, H before V.
- bricks_left updates in the cycle after its erase pulse.
- level_clear is registered and follows bricks_left.
- Reset mid-operation returns to IDLE next edge with all outputs at reset values.

## Test plan
- Reset: bricks_left=20, level_clear=0, busy=0, all pulses 0.
- Vertical hit: ball (30,20), dir_right=1, dir_down=0.
  - Required: erase_addr=11 in cycle 5, done in cycle 6, hit=1, new_down=1, new_right=1, bricks_left=19.
  - Repeating the same request: miss, done in cycle 5, new_*=dir_*.
- Corner-only hit: load_level, then clear addr 10 via ball (5,20) up; then ball (14,20), right/up.
  - H and V miss; C hits addr 11.
  - Required: new_right=0, new_down=1, erase_addr=11.
- Double hit: ball (14,12), right/down.
  - H clears addr 11 (cycle 5), V clears addr 10 (cycle 6), done in cycle 7, bricks_left decreases by 2.
- Edges:
  - ball_x=0, dir_right=0, y=5: H miss, no underflow hit.
  - start pulsed during busy: ignored.
  - load_level in cycle 2: busy drops, no done, bricks_left=20.
- Level clear: clear all 20 bricks, then level_clear=1 and bricks_left=0; a following load_level restores 20.
